// File: rtl/dec_pkg.sv
// Shared decode constants for the 16-bit-family decode stage: opcode values,
// format-bit position and the registered instruction-class flags.
package dec_pkg;

   localparam int MOP_W = 4;

   // Memory/jump opcodes (format bit set)
   localparam logic [MOP_W-1:0] MOP_JMP_LIM = 4'd6;
   localparam logic [MOP_W-1:0] MOP_LI      = 4'd6;
   localparam logic [MOP_W-1:0] MOP_LM      = 4'd7;
   localparam logic [MOP_W-1:0] MOP_ST      = 4'd8;
   localparam logic [MOP_W-1:0] MOP_LDIP    = 4'd9;

   // ALU opcodes (format bit clear); 1..6 and 8..16 are register-writing ops
   localparam logic [31:0] OP_NOP      = 32'd0;
   localparam logic [31:0] OP_ADD      = 32'd1;
   localparam logic [31:0] OP_RW_A_HI  = 32'd6;
   localparam logic [31:0] OP_RW_B_LO  = 32'd8;
   localparam logic [31:0] OP_RW_B_HI  = 32'd16;
   localparam logic [31:0] OP_SHOWR    = 32'd18;
   localparam logic [31:0] OP_SHOWRSEG = 32'd19;
   localparam logic [31:0] OP_CMP      = 32'd20;

   typedef struct packed {
      logic rw;
      logic is_jump;
      logic is_load;
      logic is_store;
      logic illegal;
   } dec_cls_t;

   function automatic int fmt_bit(input int inst_w);
      return inst_w - 1;
   endfunction

   function automatic dec_cls_t classify(input logic fmt, input logic [MOP_W-1:0] mop,
                                         input logic [31:0] aluop);
      dec_cls_t c;
      c = '0;
      if (fmt) begin
         if (mop < MOP_JMP_LIM) begin
            c.is_jump = 1'b1;
         end else if (mop == MOP_LI || mop == MOP_LM || mop == MOP_LDIP) begin
            c.is_load = 1'b1;
            c.rw      = 1'b1;
         end else if (mop == MOP_ST) begin
            c.is_store = 1'b1;
         end else begin
            c.illegal = 1'b1;
         end
      end else begin
         if ((aluop >= OP_ADD && aluop <= OP_RW_A_HI) ||
             (aluop >= OP_RW_B_LO && aluop <= OP_RW_B_HI) || aluop == OP_CMP) begin
            c.rw = 1'b1;
         end else if (!(aluop == OP_NOP || aluop == OP_SHOWR || aluop == OP_SHOWRSEG)) begin
            c.illegal = 1'b1;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/dec_scoreboard.sv
// Pending-load register scoreboard: one bit per register, set when a load
// leaves decode and cleared on writeback; queried with a register-use mask.
module dec_scoreboard
   import dec_pkg::*;
#(
   parameter int  REG_W = 3,
   localparam int NREG  = 2**REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_idx,
   input  logic [NREG-1:0]  use_mask,
   output logic             hit
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] busy;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_idx] = 1'b1;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
      // a writeback this cycle already frees the register for the query
      busy = pending & ~clr_mask;
      hit  = |(use_mask & busy);
   end

   // set is applied after clear so a same-cycle set/clear leaves the bit pending
   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~clr_mask) | set_mask;
   end

endmodule

// File: rtl/dec_stage.sv
// Registered instruction-decode stage: valid/ready handshake, field and class
// decode, and load-use stall against the pending-register scoreboard.
module dec_stage
   import dec_pkg::*;
#(
   parameter int  INST_W  = 16,
   parameter int  REG_W   = 3,
   localparam int ADDR_W  = INST_W - 5 - REG_W,
   localparam int ALUOP_W = INST_W - 1 - 2*REG_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_flush,
   input  logic               i_valid,
   input  logic [INST_W-1:0]  i_inst,
   output logic               o_ready,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [ALUOP_W-1:0] o_aluOp,
   output logic [REG_W-1:0]   o_in1,
   output logic [REG_W-1:0]   o_in2,
   output logic [MOP_W-1:0]   o_aluOp_1,
   output logic [REG_W-1:0]   o_in_2,
   output logic [ADDR_W-1:0]  o_in_1,
   output logic               o_rw,
   output logic               o_isJump,
   output logic               o_isLoad,
   output logic               o_isStore,
   output logic               o_illegal,
   input  logic               i_wb_valid,
   input  logic [REG_W-1:0]   i_wb_idx
);

   localparam int NREG = 2**REG_W;
   localparam int FMT  = fmt_bit(INST_W);

   logic [ALUOP_W-1:0] aluop_d;
   logic [REG_W-1:0]   in1_d;
   logic [REG_W-1:0]   in2_d;
   logic [MOP_W-1:0]   mop_d;
   logic [REG_W-1:0]   rin_d;
   logic [ADDR_W-1:0]  imm_d;
   logic [REG_W-1:0]   dst;
   logic               alu_src;
   logic [NREG-1:0]    use_mask;
   dec_cls_t           cls;
   dec_cls_t           cls_q;
   logic               sb_hit;
   logic               held_hit;
   logic               hazard;
   logic               fire_in;
   logic               leave;

   always_comb begin
      aluop_d  = i_inst[INST_W-2 -: ALUOP_W];
      in1_d    = i_inst[2*REG_W-1 -: REG_W];
      in2_d    = i_inst[REG_W-1:0];
      mop_d    = i_inst[INST_W-2 -: MOP_W];
      rin_d    = i_inst[INST_W-6 -: REG_W];
      imm_d    = i_inst[ADDR_W-1:0];
      cls      = classify(i_inst[FMT], mop_d, 32'(aluop_d));
      alu_src  = !i_inst[FMT] && !cls.illegal;
      // loads write the memory-format register field, ALU ops write in1
      dst      = i_inst[FMT] ? rin_d : in1_d;
      use_mask = '0;
      for (int i = 0; i < NREG; i++) begin
         if (alu_src && (in1_d == REG_W'(i) || in2_d == REG_W'(i))) use_mask[i] = 1'b1;
         if (cls.is_store && rin_d == REG_W'(i))                     use_mask[i] = 1'b1;
         if (cls.rw && dst == REG_W'(i))                             use_mask[i] = 1'b1;
      end
   end

   // a load still held here is not in the scoreboard yet, so check it directly
   assign held_hit = o_valid & cls_q.is_load & use_mask[o_in_2];
   assign hazard   = sb_hit | held_hit;
   assign o_ready  = (!o_valid | i_ready) & !hazard & !i_flush;
   assign fire_in  = i_valid & o_ready;
   assign leave    = o_valid & i_ready & !i_flush & cls_q.is_load;

   dec_scoreboard #(.REG_W(REG_W)) u_sb (
      .clk      (i_clk),
      .rst      (i_rst),
      .set_en   (leave),
      .set_idx  (o_in_2),
      .clr_en   (i_wb_valid),
      .clr_idx  (i_wb_idx),
      .use_mask (use_mask),
      .hit      (sb_hit)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid   <= 1'b0;
         o_aluOp   <= '0;
         o_in1     <= '0;
         o_in2     <= '0;
         o_aluOp_1 <= '0;
         o_in_2    <= '0;
         o_in_1    <= '0;
         cls_q     <= '0;
      end else if (fire_in) begin
         o_valid   <= 1'b1;
         o_aluOp   <= aluop_d;
         o_in1     <= in1_d;
         o_in2     <= in2_d;
         o_aluOp_1 <= mop_d;
         o_in_2    <= rin_d;
         o_in_1    <= imm_d;
         cls_q     <= cls;
      end else if (i_ready || i_flush) begin
         o_valid <= 1'b0;
      end
   end

   assign o_rw      = cls_q.rw;
   assign o_isJump  = cls_q.is_jump;
   assign o_isLoad  = cls_q.is_load;
   assign o_isStore = cls_q.is_store;
   assign o_illegal = cls_q.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: queue of expected decodes filled on accept and
// checked on consume, plus directed handshake/hazard/flush/reset checks.
module tb_dec_stage;

   logic        i_clk = 1'b0;
   logic        i_rst, i_flush, i_valid, i_ready, i_wb_valid;
   logic [15:0] i_inst;
   logic [2:0]  i_wb_idx;
   logic        o_ready, o_valid, o_rw, o_isJump, o_isLoad, o_isStore, o_illegal;
   logic [8:0]  o_aluOp;
   logic [2:0]  o_in1, o_in2, o_in_2;
   logic [3:0]  o_aluOp_1;
   logic [7:0]  o_in_1;
   logic [4:0]  flags;

   localparam logic [4:0] C_ALU = 5'b10000;
   localparam logic [4:0] C_JMP = 5'b01000;
   localparam logic [4:0] C_LD  = 5'b10100;
   localparam logic [4:0] C_ST  = 5'b00010;
   localparam logic [4:0] C_ILL = 5'b00001;

   typedef struct {
      logic [15:0] inst;
      logic [4:0]  cls;
   } exp_t;

   exp_t       sb_q[$];
   logic [4:0] cur_cls;
   int         n_chk = 0;
   int         n_err = 0;

   dec_stage #(.INST_W(16), .REG_W(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .i_inst(i_inst),
      .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
      .o_aluOp(o_aluOp), .o_in1(o_in1), .o_in2(o_in2), .o_aluOp_1(o_aluOp_1),
      .o_in_2(o_in_2), .o_in_1(o_in_1), .o_rw(o_rw), .o_isJump(o_isJump),
      .o_isLoad(o_isLoad), .o_isStore(o_isStore), .o_illegal(o_illegal),
      .i_wb_valid(i_wb_valid), .i_wb_idx(i_wb_idx)
   );

   assign flags = {o_rw, o_isJump, o_isLoad, o_isStore, o_illegal};

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic offer(input logic [15:0] inst, input logic [4:0] cls);
      i_valid = 1'b1;
      i_inst  = inst;
      cur_cls = cls;
   endtask

   task automatic wb(input logic en, input logic [2:0] idx);
      i_wb_valid = en;
      i_wb_idx   = idx;
   endtask

   // Monitor: pop on consume (or discard on flush), then push on accept
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         sb_q.delete();
      end else begin
         if (o_valid && i_flush) begin
            if (sb_q.size() > 0) e = sb_q.pop_front();
         end else if (o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_empty", 32'(o_valid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk($sformatf("alu_fields %h", e.inst), 32'({o_aluOp, o_in1, o_in2}),
                   32'({e.inst[14:6], e.inst[5:3], e.inst[2:0]}));
               chk($sformatf("mem_fields %h", e.inst), 32'({o_aluOp_1, o_in_2, o_in_1}),
                   32'({e.inst[14:11], e.inst[10:8], e.inst[7:0]}));
               chk($sformatf("class %h", e.inst), 32'(flags), 32'(e.cls));
            end
         end
         if (i_valid && o_ready) sb_q.push_back('{inst: i_inst, cls: cur_cls});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_inst = '0; i_ready = 1'b0;
      i_wb_valid = 1'b0; i_wb_idx = '0; cur_cls = '0;
      tick(); tick();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_fields", 32'({o_aluOp, o_in1, o_in2, o_aluOp_1, o_in_2}), 32'd0);
      chk("rst_flags", 32'({o_in_1, flags}), 32'd0);
      i_rst = 1'b0;
      #1 chk("rst_ready", 32'(o_ready), 32'd1);

      // add r1,r0: one-cycle latency
      i_ready = 1'b1;
      offer(16'h0048, C_ALU); tick(); i_valid = 1'b0;
      chk("add_valid", 32'(o_valid), 32'd1);
      chk("add_op", 32'(o_aluOp), 32'd1);
      chk("add_regs", 32'({o_in1, o_in2}), 32'({3'd1, 3'd0}));
      chk("add_cls", 32'(flags), 32'(C_ALU));
      tick();

      // Li r3 then add r3,r0: stalls until writeback of r3, bypassed same cycle
      offer(16'hB305, C_LD); tick();
      offer(16'h0058, C_ALU);
      #1 chk("raw_held", 32'(o_ready), 32'd0);
      tick(); chk("raw_pend", 32'(o_ready), 32'd0);
      tick(); chk("raw_pend2", 32'(o_ready), 32'd0);
      wb(1'b1, 3'd3);
      #1 chk("raw_bypass", 32'(o_ready), 32'd1);
      tick(); wb(1'b0, 3'd0); i_valid = 1'b0;
      chk("raw_issued", 32'(o_valid), 32'd1);
      tick();

      // store r2 against LM r2 held, then pending
      i_ready = 1'b0;
      offer(16'hBA00, C_LD); tick();
      offer(16'hC200, C_ST);
      #1 chk("st_bp", 32'(o_ready), 32'd0);
      i_ready = 1'b1;
      #1 chk("st_held", 32'(o_ready), 32'd0);
      tick(); chk("st_pend", 32'(o_ready), 32'd0);
      tick(); chk("st_pend2", 32'(o_ready), 32'd0);
      wb(1'b1, 3'd2);
      #1 chk("st_wb", 32'(o_ready), 32'd1);
      tick(); wb(1'b0, 3'd0); i_valid = 1'b0;
      tick();

      // illegal encodings in both formats
      offer(16'hD000, C_ILL); tick();
      offer(16'h01C0, C_ILL); tick();
      chk("ill_mem", 32'(flags), 32'(C_ILL));
      i_valid = 1'b0; tick();
      chk("ill_alu", 32'(flags), 32'(C_ILL));
      tick();

      // Li r5 leaves so r5 is pending across the flush below
      offer(16'hB500, C_LD); tick(); i_valid = 1'b0; tick();

      // jump held under backpressure, then flushed
      i_ready = 1'b0;
      offer(16'h8005, C_JMP); tick(); i_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("bp_hold", 32'({o_valid, o_aluOp_1, o_in_1, flags}), 32'({1'b1, 4'd0, 8'h05, C_JMP}));
         chk("bp_ready", 32'(o_ready), 32'd0);
         tick();
      end
      i_flush = 1'b1;
      #1 chk("fl_ready", 32'(o_ready), 32'd0);
      tick(); i_flush = 1'b0;
      chk("fl_valid", 32'(o_valid), 32'd0);
      i_ready = 1'b1;
      offer(16'h0068, C_ALU);
      #1 chk("fl_sb_kept", 32'(o_ready), 32'd0);
      wb(1'b1, 3'd5);
      #1 chk("fl_wb", 32'(o_ready), 32'd1);
      tick(); wb(1'b0, 3'd0); i_valid = 1'b0;
      tick();

      // flushed load with i_ready=1 does not mark r6 pending
      offer(16'hB600, C_LD); tick(); i_valid = 1'b0; i_flush = 1'b1;
      tick(); i_flush = 1'b0;
      offer(16'h0070, C_ALU);
      #1 chk("fl_noleave", 32'(o_ready), 32'd1);
      tick(); i_valid = 1'b0; tick();

      // set and clear of r4 in the same cycle leaves r4 pending
      offer(16'hB400, C_LD); tick(); i_valid = 1'b0;
      wb(1'b1, 3'd4); tick(); wb(1'b0, 3'd0);
      offer(16'h0060, C_ALU);
      #1 chk("setclr", 32'(o_ready), 32'd0);
      tick(); chk("setclr2", 32'(o_ready), 32'd0);
      wb(1'b1, 3'd4);
      #1 chk("setclr_wb", 32'(o_ready), 32'd1);
      tick(); wb(1'b0, 3'd0); i_valid = 1'b0;
      tick();

      // reset while stalled empties the stage and the scoreboard
      offer(16'hB700, C_LD); tick(); i_valid = 1'b0; tick();
      i_ready = 1'b0;
      offer(16'hB900, C_LD); tick(); i_valid = 1'b0;
      chk("ms_held", 32'(o_valid), 32'd1);
      i_rst = 1'b1; tick(); i_rst = 1'b0;
      chk("ms_valid", 32'(o_valid), 32'd0);
      chk("ms_flags", 32'(flags), 32'd0);
      i_ready = 1'b1;
      offer(16'h0078, C_ALU);
      #1 chk("ms_sb", 32'(o_ready), 32'd1);
      tick(); i_valid = 1'b0;
      tick(); tick();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dec_stage.md
Name: dec_stage

Overview:
Registered, parametrised instruction-decode pipeline stage for the 16-bit-family core. It accepts one instruction per cycle through a valid/ready handshake and decodes its fields and class (ALU, jump, load, store, illegal). A register-index scoreboard blocks instructions that read or write a register with an outstanding load. The stage sits between fetch and execute and replaces the purely combinational decoder in the pipelined core.

Parameters:
INST_W, 16, instruction width; MSB is the format bit.
REG_W, 3, register-index width; NREG = 2**REG_W registers.
ADDR_W (derived, not overridable), INST_W-5-REG_W, immediate/address width (8 at defaults).
ALUOP_W (derived), INST_W-1-2*REG_W, ALU opcode width (9 at defaults).

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; synchronous, active-high
i_flush  in  1  discard held instruction
i_valid  in  1  instruction offered
i_inst  in  INST_W  instruction
o_ready  out  1  stage accepts this cycle
o_valid  out  1  decoded instruction held
i_ready  in  1  execute consumes this cycle
o_aluOp  out  ALUOP_W  ALU opcode, i_inst[INST_W-2:2*REG_W]
o_in1  out  REG_W  i_inst[2*REG_W-1:REG_W]; ALU destination and source 1
o_in2  out  REG_W  i_inst[REG_W-1:0]; ALU source 2
o_aluOp_1  out  4  i_inst[INST_W-2:INST_W-5]; memory/jump opcode
o_in_2  out  REG_W  memory/jump register field, directly below o_aluOp_1
o_in_1  out  ADDR_W  i_inst[ADDR_W-1:0]; immediate/address
o_rw  out  1  register write enable
o_isJump / o_isLoad / o_isStore / o_illegal  out  1 each  class flags
i_wb_valid  in  1  load writeback this cycle
i_wb_idx  in  REG_W  register written back

Behaviour:
- Reset: o_valid=0, all decoded outputs and flags 0, scoreboard cleared. Reset overrides flush and every other input.
- Classification (MSB=1), by o_aluOp_1:
  - 0..5: jump.
  - 6 (Li), 7 (LM), 9 (LDip): load, rw=1.
  - 8: store, rw=0.
  - 10..15: illegal, rw=0.
- Classification (MSB=0), by o_aluOp:
  - rw=1 for codes 1-6, 8-16, 20.
  - rw=0 for code 0 (nop), 18 (showr), 19 (showrSeg).
  - All other codes: illegal, rw=0.
- Illegal instructions propagate with all other class flags 0.
- Handshake:
  - fire_in = i_valid & o_ready.
  - o_ready = (!o_valid | i_ready) & !hazard & !i_flush.
  - On fire_in the register loads the decode result: latency 1 cycle. Otherwise, if i_ready, o_valid clears; else the register holds.
  - Outputs are stable while o_valid=1 and i_ready=0.
- Hazard, combinational on i_inst:
  - Source set: ALU ops read o_in1 and o_in2. Store reads o_in_2. Loads and jumps read nothing.
  - Destination check applies when rw=1.
  - hazard = any source or destination index X (when used) has pending[X]=1 and no same-cycle clear (i_wb_valid & i_wb_idx==X), OR the held instruction is a valid load whose o_in_2 == X.
- Scoreboard: pending[o_in_2] is set when a load leaves the stage (o_valid & i_ready & o_isLoad). pending[i_wb_idx] is cleared on i_wb_valid.
  - Set and clear on the same index in the same cycle: pending ends at 1.
  - Clear of a non-pending index: no effect.
- Flush: o_valid clears next cycle; the held instruction is not counted as leaving. No accept in a flush cycle. Scoreboard is unaffected by flush.
- Reset mid-stall: the stage is empty and the scoreboard clear on the next cycle.

Decomposition:
- Shared package `dec_pkg`: format-bit position, memory/jump opcode constants (Li=6, LM=7, Store=8, LDip=9, jump limit 6), ALU opcode constants (nop, add … CMP=20, showr, showrSeg), and the class-flag struct.
- One natural sub-module, `dec_scoreboard`: holds the NREG pending bits and the set/clear/query logic. Field decode stays combinational in the top level.

Test Plan:
- Reset, then 0x0048 (add r1,r0) with i_ready=1 → one cycle later o_valid=1, o_aluOp=1, o_in1=1, o_in2=0, o_rw=1, all class flags 0.
- 0xB305 (Li r3,0x05) leaves the stage, then 0x0058 (add r3,r0) → o_ready=0 until i_wb_valid with i_wb_idx=3; accepted in that same cycle.
- 0xC200 (store r2) offered while a valid LM r2 is held with i_ready=0 → o_ready=0. Once LM leaves, pending[2] is set; store is still stalled until writeback of index 2.
- Illegal instructions 0xD000 and 0x01C0 → o_illegal=1, o_rw=0, other class flags 0.
- Backpressure: i_ready=0 for 3 cycles holding 0x8005 (jump) → outputs unchanged, o_ready=0. Then i_flush=1 → o_valid=0 next cycle, scoreboard unchanged.
- i_wb_valid with idx=4 in the same cycle a load to r4 leaves → pending[4]=1 afterwards.
